// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative HI/LO multiply / divide unit for the execute stage.
// One operation in flight; MUL runs a fixed MUL_LAT cycles, DIV is a radix-2
// restoring divider producing one quotient bit per cycle on magnitudes, with
// the sign fixup folded into the edge that writes hi/lo.
module muldiv_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Captured operation context
  logic [CW-1:0]      cnt;
  logic [1:0]         acc_mode;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;

  // Restoring divider working registers
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  // Control decode
  logic               accept;
  logic               write_result;

  // Operand preparation at accept time
  logic               in_signed;
  logic               in_sign_a;
  logic               in_sign_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic               in_is_div;

  // Multiply datapath
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;

  // Divide datapath
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   a_orig;
  logic [2*WIDTH-1:0] div_res;
  logic [2*WIDTH-1:0] result;

  assign busy = (state == MUL) || (state == DIV);

  // Convert incoming operands to sign + magnitude; unsigned ops never carry a sign
  always_comb begin
    in_signed = ~op[0];
    in_sign_a = in_signed & a[WIDTH-1];
    in_sign_b = in_signed & b[WIDTH-1];
    in_mag_a  = in_sign_a ? -a : a;
    in_mag_b  = in_sign_b ? -b : b;
    in_is_div = (op[2:1] == 2'b01);
  end

  // State register; reset and cancel both return the unit to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: accept in IDLE/DONE, finish on the last MUL/DIV cycle
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    write_result = 1'b0;
    if (cancel) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            accept     = 1'b1;
            state_next = in_is_div ? DIV : MUL;
          end else begin
            state_next = IDLE;
          end
        end
        MUL: begin
          if (cnt == CW'(MUL_LAT)) begin
            state_next   = DONE;
            write_result = 1'b1;
          end
        end
        DIV: begin
          if (cnt == CW'(WIDTH - 1)) begin
            state_next   = DONE;
            write_result = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Signed product from magnitudes, then optional accumulate or subtract
  always_comb begin
    prod_mag = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    prod     = (sign_a ^ sign_b) ? -prod_mag : prod_mag;
    case (acc_mode)
      2'b10:   mul_res = acc + prod;
      2'b11:   mul_res = acc - prod;
      default: mul_res = prod;
    endcase
  end

  // One restoring step, plus the sign fixup used on the final iteration
  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    q_bit     = ~div_diff[WIDTH];
    rem_next  = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], q_bit};
    quo_fix   = (sign_a ^ sign_b) ? -quo_next : quo_next;
    rem_fix   = sign_a ? -rem_next : rem_next;
    a_orig    = sign_a ? -mag_a : mag_a;
    if (mag_b == '0) begin
      div_res = {a_orig, {WIDTH{1'b1}}};
    end else begin
      div_res = {rem_fix, quo_fix};
    end
    result = (state == MUL) ? mul_res : div_res;
  end

  // Capture operands on accept and advance the cycle/iteration counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc_mode <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
    end else if (accept) begin
      cnt      <= in_is_div ? CW'(0) : CW'(1);
      acc_mode <= op[2:1];
      sign_a   <= in_sign_a;
      sign_b   <= in_sign_b;
      mag_a    <= in_mag_a;
      mag_b    <= in_mag_b;
      acc      <= {hi_in, lo_in};
      rem      <= '0;
      quo      <= in_mag_a;
    end else if (cancel) begin
      cnt      <= '0;
    end else if (state == MUL) begin
      cnt      <= cnt + CW'(1);
    end else if (state == DIV) begin
      cnt      <= cnt + CW'(1);
      rem      <= rem_next;
      quo      <= quo_next;
    end
  end

  // Result registers and done pulse, written only on a completing edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= write_result;
      if (write_result) begin
        hi <= result[2*WIDTH-1:WIDTH];
        lo <= result[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed vectors for muldiv_iter with a transaction-level
// reference model compared against the outputs every cycle.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cancel;
  logic [2:0]  op;
  logic [31:0] a, b, hi_in, lo_in;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int cycle_count = 0;
  int accept_cycle = 0;

  // Reference model state
  logic        m_pending = 1'b0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_res = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_iter #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .hi_in  (hi_in),
    .lo_in  (lo_in),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // Free-running cycle index used to measure latency
  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Arithmetic meaning of each op, computed with wide plain arithmetic
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [31:0] h,
                                               input logic [31:0] l);
    longint      sx, sy;
    logic [63:0] prod;
    logic [63:0] accv;
    accv = {h, l};
    sx = $signed(x);
    sy = $signed(y);
    if (o[2:1] == 2'b01) begin
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (o[0]) return {x % y, x / y};
      return {32'(sx % sy), 32'(sx / sy)};
    end
    if (o[0]) prod = {32'd0, x} * {32'd0, y};
    else      prod = 64'(sx * sy);
    case (o[2:1])
      2'b10:   return accv + prod;
      2'b11:   return accv - prod;
      default: return prod;
    endcase
  endfunction

  // One operation in flight: accept when idle, count down latency, then publish
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pending <= 1'b0;
      m_left    <= 0;
      m_done    <= 1'b0;
      m_res     <= '0;
      m_hi      <= '0;
      m_lo      <= '0;
    end else begin
      m_done <= 1'b0;
      if (cancel) begin
        m_pending <= 1'b0;
      end else if (m_pending) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi      <= m_res[63:32];
          m_lo      <= m_res[31:0];
          m_done    <= 1'b1;
          m_pending <= 1'b0;
        end
      end else if (start) begin
        m_pending <= 1'b1;
        m_res     <= model_result(op, a, b, hi_in, lo_in);
        m_left    <= (op[2:1] == 2'b01) ? 32 : 2;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model on every cycle outside reset
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check_output("model busy", 64'(busy), 64'(m_pending));
      check_output("model done", 64'(done), 64'(m_done));
      check_output("model hi", 64'(hi), 64'(m_hi));
      check_output("model lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic apply_stimulus(input bit immediate, input logic [2:0] o, input logic [31:0] x,
                                input logic [31:0] y, input logic [31:0] h, input logic [31:0] l);
    if (!immediate) begin
      @(posedge clk);
      #1;
    end
    op    = o;
    a     = x;
    b     = y;
    hi_in = h;
    lo_in = l;
    start = 1'b1;
    accept_cycle = cycle_count;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else check_output({name, " busy before done"}, 64'(busy), 64'd1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: actual=no done required=done in cycle %0d", name, exp_cyc);
    end else begin
      check_output({name, " done cycle"}, 64'(cycle_count - accept_cycle), 64'(exp_cyc));
      check_output({name, " busy in done"}, 64'(busy), 64'd0);
      check_output({name, " hi"}, 64'(hi), 64'(exp_hi));
      check_output({name, " lo"}, 64'(lo), 64'(exp_lo));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit saw_done;
    reset = 1'b1; start = 1'b0; cancel = 1'b0;
    op = '0; a = '0; b = '0; hi_in = '0; lo_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset busy", 64'(busy), 64'd0);
    check_output("reset done", 64'(done), 64'd0);
    check_output("reset hi", 64'(hi), 64'd0);
    check_output("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;

    // Multiplies
    apply_stimulus(0, 3'b000, 32'hFFFF_FFFE, 32'd3, 0, 0);
    wait_done("MULT -2*3", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    apply_stimulus(0, 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 0, 0);
    wait_done("MULT -3*-5", 3, 32'h0, 32'd15);
    apply_stimulus(0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    wait_done("MULTU max*max", 3, 32'hFFFF_FFFE, 32'h0000_0001);

    // Divides
    apply_stimulus(0, 3'b011, 32'd100, 32'd7, 0, 0);
    wait_done("DIVU 100/7", 33, 32'd2, 32'd14);
    apply_stimulus(0, 3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0);
    wait_done("DIV -7/2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    apply_stimulus(0, 3'b010, 32'd7, 32'hFFFF_FFFE, 0, 0);
    wait_done("DIV 7/-2", 33, 32'd1, 32'hFFFF_FFFD);
    apply_stimulus(0, 3'b011, 32'hFFFF_FFFF, 32'h10, 0, 0);
    wait_done("DIVU max/16", 33, 32'hF, 32'h0FFF_FFFF);

    // Divide corner cases
    apply_stimulus(0, 3'b010, 32'd5, 32'd0, 0, 0);
    wait_done("DIV 5/0", 33, 32'd5, 32'hFFFF_FFFF);
    apply_stimulus(0, 3'b010, 32'hFFFF_FFF0, 32'd0, 0, 0);
    wait_done("DIV -16/0", 33, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    apply_stimulus(0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    wait_done("DIV min/-1", 33, 32'h0, 32'h8000_0000);

    // Accumulate forms
    apply_stimulus(0, 3'b101, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("MADDU wrap", 3, 32'h0, 32'h0);
    apply_stimulus(0, 3'b110, 32'd1, 32'd1, 32'h0, 32'h0);
    wait_done("MSUB wrap", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    apply_stimulus(0, 3'b111, 32'd2, 32'd3, 32'h0, 32'd10);
    wait_done("MSUBU 10-6", 3, 32'h0, 32'd4);
    apply_stimulus(0, 3'b100, 32'hFFFF_FFFF, 32'd3, 32'h0, 32'd10);
    wait_done("MADD 10+(-3)", 3, 32'h0, 32'd7);
    apply_stimulus(0, 3'b100, 32'd3, 32'd4, 32'd1, 32'd2);
    hi_in = 32'hDEAD_BEEF;
    lo_in = 32'h1234_5678;
    wait_done("MADD late hi_in", 3, 32'd1, 32'd14);

    // Ignored start during divide, then cancel
    apply_stimulus(0, 3'b011, 32'd100, 32'd7, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    op = 3'b001; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check_output("cancel busy cleared", 64'(busy), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    check_output("cancel no done", 64'(saw_done), 64'd0);
    check_output("cancel hi kept", 64'(hi), 64'd1);
    check_output("cancel lo kept", 64'(lo), 64'd14);

    // Back-to-back accept in the done cycle
    apply_stimulus(0, 3'b000, 32'hFFFF_FFFE, 32'd3, 0, 0);
    wait_done("b2b first", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    apply_stimulus(1, 3'b001, 32'd3, 32'd4, 0, 0);
    wait_done("b2b MULTU 3*4", 3, 32'h0, 32'd12);

    // Asynchronous reset in the middle of a divide
    apply_stimulus(0, 3'b011, 32'd100, 32'd7, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    check_output("mid div busy", 64'(busy), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check_output("async reset busy", 64'(busy), 64'd0);
    check_output("async reset done", 64'(done), 64'd0);
    check_output("async reset hi", 64'(hi), 64'd0);
    check_output("async reset lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    apply_stimulus(0, 3'b000, 32'd2, 32'd3, 0, 0);
    wait_done("MULT after reset", 3, 32'h0, 32'd6);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the execute stage: it accepts one HI/LO-class operation (signed or unsigned multiply, divide, multiply-accumulate or multiply-subtract) per start pulse. It runs a fixed-latency multiply path or a radix-2 restoring divide path (one quotient bit per cycle), and returns a registered {hi, lo} pair with a one-cycle done pulse. It replaces the separate multiplier and divider instances. The execute stage uses busy/done to stall the pipeline and cancel to kill in-flight work on exceptions or flushes.

## Interface
- WIDTH, 32: operand width; products and accumulators are 2*WIDTH.
- MUL_LAT, 2: cycles the unit spends in state MUL; legal values are 1 or more.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when the unit is ready (state IDLE or DONE).
- op  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
  - 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- a, b  in  WIDTH  operands (a is the dividend, b is the divisor).
- hi_in, lo_in  in  WIDTH  accumulator source for MADD*/MSUB*; captured at start.
- cancel  in  1  kills any in-flight or accepted operation.
- busy  out  1  high in states MUL and DIV.
- done  out  1  one-cycle pulse; hi/lo are valid in the same cycle.
- hi, lo  out  WIDTH  result registers; they hold their value until the next done.

## Operation
- States:
  - IDLE
  - MUL (cycle counter runs 1..MUL_LAT)
  - DIV (iteration counter runs 0..WIDTH-1)
  - DONE (lasts exactly one cycle)
- Accept: start=1 and cancel=0 while in IDLE or DONE. The accepting edge captures op, a, b, hi_in and lo_in.
  - op[1]=0 or op[2]=1 goes to MUL.
  - op 010/011 goes to DIV.
- start while busy is ignored: no queueing, no effect.
- Signedness: op[0]=0 means signed. Both paths operate on magnitudes and record sign_a and sign_b.
- Multiply result:
  - P = |a|*|b|, negated modulo 2^(2*WIDTH) when the signs differ.
  - MULT/MULTU: {hi,lo} = P.
  - MADD*: {hi,lo} = {hi_in,lo_in} + P.
  - MSUB*: {hi,lo} = {hi_in,lo_in} - P.
  - All of these wrap modulo 2^(2*WIDTH).
- Divide:
  - WIDTH restoring iterations on the unsigned magnitudes.
  - Signed fixup happens on the final edge: the quotient is negated when the signs differ; the remainder takes the sign of a.
  - lo = quotient, hi = remainder.
- Divide by zero (b=0, any signedness): lo = all ones, hi = a. Latency is unchanged.
- Signed minimum / -1: lo = minimum (wraps), hi = 0. No exception is raised; overflow detection is not this block's job.
- Cancel, in any state:
  - The next edge goes to IDLE.
  - done stays 0 and hi/lo are not written.
  - cancel together with start in IDLE/DONE means the request is not accepted.
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, all counters 0. Reset takes effect immediately, without waiting for clk, including mid-operation.

## Timing
- Cycle numbering: cycle 0 is the cycle in which start is accepted.
- Multiply: state is MUL during cycles 1..MUL_LAT. hi/lo are written at the end of cycle MUL_LAT. done=1 in cycle MUL_LAT+1.
- Divide: one iteration per cycle in cycles 1..WIDTH. hi/lo are written with the fixup at the end of cycle WIDTH. done=1 in cycle WIDTH+1.
- busy=1 exactly in cycles 1..MUL_LAT (multiply) or 1..WIDTH (divide). busy=0 in the done cycle.
- Back-to-back: a start in the done cycle is accepted. The next done follows after the full latency again, with no dead cycle.
- done is registered and never high two cycles in a row.
- hi/lo change only on the edge that precedes done.
- Throughput: one operation in flight, at most.

## Test plan
All scenarios use WIDTH=32, MUL_LAT=2.

1. Signed multiply: MULT a=0xFFFFFFFE, b=3 -> done in cycle 3, hi=0xFFFFFFFF, lo=0xFFFFFFFA. busy=1 in cycles 1-2 only.
2. Divide:
   - DIVU a=100, b=7 -> done in cycle 33, lo=14, hi=2.
   - DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. Divide corner cases:
   - DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=5, done in cycle 33.
   - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Accumulate wrap:
   - MADDU hi_in=lo_in=0xFFFFFFFF, a=b=1 -> hi=0, lo=0.
   - MSUB hi_in=lo_in=0, a=b=1 -> hi=lo=0xFFFFFFFF.
   - Changing hi_in after the accept cycle has no effect on the result.
5. Cancel and ignored start:
   - Start DIVU, pulse start with other operands in cycle 5 -> ignored.
   - cancel in cycle 10 -> busy=0 from cycle 11, no done ever appears, hi/lo keep the prior result.
6. Back-to-back and reset:
   - MULTU 3*4 accepted in its done cycle right after a prior MULT -> second done 3 cycles later with lo=12.
   - Assert reset mid-DIV between clock edges -> busy, done, hi and lo go to 0 before the next edge.
